// File: rtl/mem_wr_arb_pkg.sv
// rtl/mem_wr_arb_pkg.sv - shared state encoding, command fields and AXI codes for mem_wr_arb
package mem_wr_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    CMD   = 3'd2,
    ADDR  = 3'd3,
    DATA  = 3'd4,
    RESP  = 3'd5
  } state_t;

  localparam int CMD_LEN_MSB  = 7;
  localparam int CMD_LEN_LSB  = 0;
  localparam int CMD_LAST_BIT = 9;

  localparam logic [1:0] AXI_OKAY = 2'b00;

endpackage

// File: rtl/wr_burst_fifo.sv
// rtl/wr_burst_fifo.sv - synchronous first-word-fall-through burst buffer, DEPTH x 32
module wr_burst_fifo #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        full,
  output logic        empty
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full    = (r_count == FULL_CNT);
  assign empty   = (r_count == '0);
  assign w_push  = wr_en && !full;
  assign w_pop   = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_wr_arb.sv
// rtl/mem_wr_arb.sv - two-requester round-robin arbiter feeding one AXI write burst at a time
module mem_wr_arb
  import mem_wr_arb_pkg::*;
#(
  parameter int BUF_DEPTH = 256,
  parameter int BUF_AW    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  output logic        ack0,
  output logic        ack1,
  input  logic [31:0] din0,
  input  logic [31:0] din1,
  input  logic        vin0,
  input  logic        vin1,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [1:0]  frm_done,
  output logic        err,
  input  logic        err_clr,
  output logic        busy
);

  state_t      r_state;
  state_t      w_next;
  logic        r_sel;
  logic        r_last_gnt;
  logic [7:0]  r_len_m1;
  logic        r_last;
  logic [7:0]  r_in_cnt;
  logic [7:0]  r_w_cnt;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_ack0;
  logic        r_ack1;
  logic [31:0] r_awaddr;
  logic [7:0]  r_awlen;
  logic        r_awvalid;
  logic [1:0]  r_frm_done;
  logic        r_err;

  logic        w_vin;
  logic [31:0] w_din;
  logic        w_pick;
  logic        w_fifo_wr;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_last_word;
  logic        w_w_hs;
  logic        w_b_hs;
  logic        w_err_set;

  assign w_vin       = r_sel ? vin1 : vin0;
  assign w_din       = r_sel ? din1 : din0;
  // On contention the requester not granted last wins; a lone request always wins.
  assign w_pick      = (req0 && req1) ? ~r_last_gnt : req1;
  assign w_fifo_wr   = (r_state == DATA) && w_vin;
  assign w_last_word = w_fifo_wr && (r_in_cnt == r_len_m1);
  assign wvalid      = ~w_fifo_empty;
  assign wlast       = wvalid && (r_w_cnt == r_awlen);
  assign w_w_hs      = wvalid && wready;
  assign bready      = (r_state == RESP) && r_aw_done && r_w_done;
  assign w_b_hs      = bvalid && bready;
  assign w_err_set   = (w_b_hs && (bresp != AXI_OKAY)) || (w_fifo_wr && w_fifo_full);
  assign busy        = (r_state != IDLE);

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign awaddr   = r_awaddr;
  assign awlen    = r_awlen;
  assign awvalid  = r_awvalid;
  assign frm_done = r_frm_done;
  assign err      = r_err;

  wr_burst_fifo #(
    .DEPTH (BUF_DEPTH),
    .AW    (BUF_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_fifo_wr),
    .wr_data (w_din),
    .rd_en   (w_w_hs),
    .rd_data (wdata),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req0 || req1) w_next = GRANT;
      GRANT:   w_next = CMD;
      CMD:     if (w_vin) w_next = ADDR;
      ADDR:    if (w_vin) w_next = DATA;
      DATA:    if (w_last_word) w_next = RESP;
      RESP:    if (w_b_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel      <= 1'b0;
      r_last_gnt <= 1'b1;
      r_len_m1   <= '0;
      r_last     <= 1'b0;
      r_in_cnt   <= '0;
      r_w_cnt    <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_awaddr   <= '0;
      r_awlen    <= '0;
      r_awvalid  <= 1'b0;
      r_frm_done <= '0;
      r_err      <= 1'b0;
    end else begin
      r_ack0     <= (r_state == GRANT) && !r_sel;
      r_ack1     <= (r_state == GRANT) && r_sel;
      r_frm_done <= '0;
      if (r_state == IDLE && (req0 || req1)) begin
        r_sel      <= w_pick;
        r_last_gnt <= w_pick;
      end
      if (r_state == GRANT) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_in_cnt  <= '0;
        r_w_cnt   <= '0;
      end
      if (r_state == CMD && w_vin) begin
        r_len_m1 <= w_din[CMD_LEN_MSB:CMD_LEN_LSB];
        r_last   <= w_din[CMD_LAST_BIT];
      end
      if (r_state == ADDR && w_vin) begin
        r_awaddr  <= w_din;
        r_awlen   <= r_len_m1;
        r_awvalid <= 1'b1;
      end else if (r_awvalid && awready) begin
        r_awvalid <= 1'b0;
        r_aw_done <= 1'b1;
      end
      if (w_fifo_wr) r_in_cnt <= r_in_cnt + 1'b1;
      if (w_w_hs) begin
        if (wlast) begin
          r_w_cnt  <= '0;
          r_w_done <= 1'b1;
        end else begin
          r_w_cnt  <= r_w_cnt + 1'b1;
        end
      end
      if (w_b_hs && r_last) r_frm_done[r_sel] <= 1'b1;
      // A new error outranks a simultaneous clear.
      r_err <= w_err_set || (r_err && !err_clr);
    end
  end

endmodule

// File: tb/tb_mem_wr_arb.sv
// tb/tb_mem_wr_arb.sv - scoreboard bench for mem_wr_arb with directed bursts
module tb_mem_wr_arb;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, ack0, ack1;
  logic [31:0] din0, din1;
  logic        vin0, vin1;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [1:0]  frm_done;
  logic        err, err_clr, busy;

  mem_wr_arb #(.BUF_DEPTH(256), .BUF_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .ack0(ack0), .ack1(ack1),
    .din0(din0), .din1(din1), .vin0(vin0), .vin1(vin1),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .frm_done(frm_done), .err(err), .err_clr(err_clr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total;
  int          bad;
  logic [39:0] aw_q[$];
  logic [32:0] w_q[$];
  logic [1:0]  ack_q[$];
  logic [1:0]  frm_q[$];
  logic [1:0]  bresp_next;
  bit          wr_toggle;
  int          aw_delay;
  int          aw_wt;
  bit          ok_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event/timeout expected none", name);
  endtask

  // Monitors: pop the next expected item whenever the DUT presents one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wvalid && wready) begin
        if (w_q.size() == 0) miss("w_unexpected");
        else chk("w_beat", {31'd0, wlast, wdata}, {31'd0, w_q.pop_front()});
      end
      if (awvalid && awready) begin
        if (aw_q.size() == 0) miss("aw_unexpected");
        else chk("aw", {24'd0, awaddr, awlen}, {24'd0, aw_q.pop_front()});
      end
      if (ack0 || ack1) begin
        if (ack_q.size() == 0) miss("ack_unexpected");
        else chk("ack", {62'd0, ack1, ack0}, {62'd0, ack_q.pop_front()});
      end
      if (frm_done != 2'b00) begin
        if (frm_q.size() == 0) miss("frm_unexpected");
        else chk("frm_done", {62'd0, frm_done}, {62'd0, frm_q.pop_front()});
      end
    end
  end

  initial begin
    awready = 1'b1;
    aw_wt = 0;
    forever begin
      @(posedge clk); #1;
      if (!awvalid) begin
        aw_wt = 0;
        awready = (aw_delay == 0);
      end else begin
        awready = (aw_wt >= aw_delay);
        aw_wt++;
      end
    end
  end

  initial begin
    wready = 1'b1;
    forever begin
      @(posedge clk); #1;
      wready = wr_toggle ? ~wready : 1'b1;
    end
  end

  initial begin
    bvalid = 1'b0;
    bresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (bvalid) begin
        bvalid = 1'b0;
        bresp = 2'b00;
      end else if (bready) begin
        bvalid = 1'b1;
        bresp = bresp_next;
      end
    end
  end

  task automatic drv(input int r, input logic rq, input logic v, input logic [31:0] d);
    if (r == 0) begin req0 = rq; vin0 = v; din0 = d; end
    else        begin req1 = rq; vin1 = v; din1 = d; end
  endtask

  task automatic wait_ack(input int r, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      if ((r == 0) ? ack0 : ack1) begin ok = 1'b1; break; end
    end
    if (!ok) miss($sformatf("ack%0d_timeout", r));
  endtask

  task automatic burst(input int r, input logic [31:0] cmd, input logic [31:0] addr,
                       input logic [31:0] seed);
    bit ok;
    int n;
    logic [7:0] len;
    len = cmd[7:0];
    n = int'(len) + 1;
    drv(r, 1'b1, 1'b0, 32'd0);
    wait_ack(r, ok);
    drv(r, 1'b0, 1'b0, 32'd0);
    if (!ok) return;
    aw_q.push_back({addr, len});
    for (int i = 0; i < n; i++) w_q.push_back({(i == n - 1), seed + 32'(i)});
    if (cmd[9]) frm_q.push_back((r == 0) ? 2'b01 : 2'b10);
    drv(r, 1'b0, 1'b1, cmd);  @(posedge clk); #1;
    drv(r, 1'b0, 1'b1, addr); @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      drv(r, 1'b0, 1'b1, seed + 32'(i)); @(posedge clk); #1;
    end
    drv(r, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (!busy && w_q.size() == 0 && !bvalid) begin ok = 1'b1; break; end
    end
    if (!ok) miss({name, "_timeout"});
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_aw_left"},  64'(aw_q.size()),  64'd0);
    chk({name, "_w_left"},   64'(w_q.size()),   64'd0);
    chk({name, "_ack_left"}, 64'(ack_q.size()), 64'd0);
    chk({name, "_frm_left"}, 64'(frm_q.size()), 64'd0);
  endtask

  task automatic clr_on_b();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      if (bready) begin seen = 1'b1; break; end
    end
    if (!seen) miss("bready_timeout");
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    bresp_next = 2'b00; wr_toggle = 1'b0; aw_delay = 0;
    req0 = 0; req1 = 0; vin0 = 0; vin1 = 0; din0 = '0; din1 = '0; err_clr = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {55'd0, ack0, ack1, awvalid, wvalid, wlast, bready, frm_done, err, busy}, 64'd0);
    chk("reset_awaddr", {32'd0, awaddr}, 64'd0);
    chk("reset_awlen", {56'd0, awlen}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    ack_q.push_back(2'b01); ack_q.push_back(2'b10);
    fork
      burst(0, 32'h003, 32'h1000_0000, 32'hA000_0000);
      burst(1, 32'h003, 32'h2000_0000, 32'hB000_0000);
    join
    wait_done("cont1");
    ack_q.push_back(2'b01); ack_q.push_back(2'b10);
    fork
      burst(0, 32'h002, 32'h1000_0100, 32'hA100_0000);
      burst(1, 32'h001, 32'h2000_0100, 32'hB100_0000);
    join
    wait_done("cont2");

    ack_q.push_back(2'b01);
    burst(0, 32'h03F, 32'h0140_0040, 32'hC000_0000);
    wait_done("single");

    wr_toggle = 1'b1; aw_delay = 20;
    ack_q.push_back(2'b10);
    burst(1, 32'h03F, 32'h0200_0000, 32'hD000_0000);
    wait_done("bp");
    wr_toggle = 1'b0; aw_delay = 0;
    chk("bp_err", {63'd0, err}, 64'd0);

    ack_q.push_back(2'b01);
    burst(0, 32'h23F, 32'h0300_0000, 32'hE000_0000);
    wait_done("frame");

    bresp_next = 2'b10;
    ack_q.push_back(2'b10);
    burst(1, 32'h001, 32'h0400_0000, 32'hF000_0000);
    wait_done("err");
    chk("err_set", {63'd0, err}, 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("err_held", {63'd0, err}, 64'd1);
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    chk("err_clr", {63'd0, err}, 64'd0);
    ack_q.push_back(2'b01);
    fork
      burst(0, 32'h001, 32'h0500_0000, 32'h1111_0000);
      clr_on_b();
    join
    wait_done("err2");
    chk("err_set_wins", {63'd0, err}, 64'd1);
    bresp_next = 2'b00;
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;

    ack_q.push_back(2'b01);
    drv(0, 1'b1, 1'b0, 32'd0);
    wait_ack(0, ok_m);
    drv(0, 1'b0, 1'b0, 32'd0);
    aw_q.push_back({32'h0600_0000, 8'h3F});
    for (int i = 0; i < 9; i++) w_q.push_back({1'b0, 32'h7700_0000 + 32'(i)});
    drv(0, 1'b0, 1'b1, 32'h03F);       @(posedge clk); #1;
    drv(0, 1'b0, 1'b1, 32'h0600_0000); @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      drv(0, 1'b0, 1'b1, 32'h7700_0000 + 32'(i)); @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {55'd0, ack0, ack1, awvalid, wvalid, wlast, bready, frm_done, err, busy}, 64'd0);
    chk("rst_mid_awaddr", {32'd0, awaddr}, 64'd0);
    chk("rst_mid_awlen", {56'd0, awlen}, 64'd0);
    drv(0, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_w_left", 64'(w_q.size()), 64'd0);
    chk("rst_mid_aw_left", 64'(aw_q.size()), 64'd0);

    ack_q.push_back(2'b10);
    burst(1, 32'h007, 32'h0800_0000, 32'h9900_0000);
    wait_done("post_rst");
    chk("post_rst_err", {63'd0, err}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wr_arb.md
MEM_WR_ARB -- requirements
Module: mem_wr_arb

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: req0/req1  in  1  burst request from requester 0/1.
REQ-003 SHALL have ports: ack0/ack1  out  1  one-cycle grant pulse to requester 0/1.
REQ-004 SHALL have ports: din0/din1  in  32  cmd/addr/data stream; vin0/vin1  in  1  word valid.
REQ-005 SHALL have ports: awaddr  out  32; awlen  out  8; awvalid  out  1; awready  in  1.
REQ-006 SHALL have ports: wdata  out  32; wlast  out  1; wvalid  out  1; wready  in  1.
REQ-007 SHALL have ports: bresp  in  2; bvalid  in  1; bready  out  1.
REQ-008 SHALL have ports: frm_done  out  2  one-cycle pulse per requester; err  out  1  sticky; err_clr  in  1; busy  out  1.
REQ-009 SHALL have parameters: BUF_DEPTH, default 256, burst buffer depth in words; BUF_AW, default 8, buffer address width.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT, CMD, ADDR, DATA, RESP.
REQ-011 IDLE: with any req high, SHALL pick a requester round-robin, with priority to the one not granted last; req0 is preferred after reset; IDLE -> GRANT.
REQ-012 GRANT: SHALL assert ack of the selected requester for exactly one cycle; GRANT -> CMD.
REQ-013 CMD: SHALL wait for vin of the selected requester; SHALL capture len_m1 = din[7:0] and last = din[9]; CMD -> ADDR.
REQ-014 ADDR: on vin, SHALL capture din as awaddr, set awlen = len_m1 and assert awvalid; ADDR -> DATA.
REQ-015 awvalid SHALL stay high until the cycle awready is sampled high, then drop.
REQ-016 DATA: SHALL write every vin word into the burst buffer with no backpressure to the requester; after len_m1+1 words, DATA -> RESP.
REQ-017 Requester vin SHALL be ignored outside CMD/ADDR/DATA; vin from the non-selected requester SHALL always be ignored.
REQ-018 W channel SHALL run concurrently with DATA: wvalid = buffer not empty; wdata = buffer head (first-word-fall-through); pop on wvalid & wready.
REQ-019 wlast SHALL be high on the word whose W count equals awlen; the W count SHALL reset per burst.
REQ-020 RESP: SHALL assert bready once both the AW handshake and the wlast handshake have occurred; on bvalid & bready, RESP -> IDLE.
REQ-021 bresp != 2'b00 SHALL set err; err SHALL clear only on err_clr; when set and clear coincide, set SHALL win.
REQ-022 On B completion of a burst with last=1, frm_done[sel] SHALL pulse one cycle.
REQ-023 Earliest IDLE re-entry SHALL be 2 cycles after the final data word, so a stale req from the finished requester is never re-granted.
REQ-024 busy SHALL equal (state != IDLE).
REQ-025 Buffer overflow (write while full) SHALL set err and drop the word; it is unreachable for len_m1 < BUF_DEPTH.
REQ-026 Latency: ack SHALL occur 2 cycles after req is sampled in IDLE; awvalid SHALL rise the cycle after the address word.

Reset
REQ-027 On rst_n low, all outputs SHALL be 0: ack, awvalid, wvalid (buffer empty), wlast, bready, frm_done, err, busy; awaddr = 0; awlen = 0.
REQ-028 Reset SHALL force the state to IDLE, set the last-granted pointer to 1 (req0 first), and empty the buffer.
REQ-029 Reset asserted mid-burst SHALL abandon the transaction without completing any AXI handshake.

Structure
REQ-030 Package mem_wr_arb_pkg SHALL hold the state encoding, cmd field positions (LEN 7:0, LAST bit 9) and AXI_OKAY = 2'b00.
REQ-031 The burst buffer SHALL be one sub-module, wr_burst_fifo: synchronous, FWFT, BUF_DEPTH x 32, with full/empty flags.

Verification
REQ-032 Single burst: req0; cmd 0x03F, addr 0x0140_0040, 64 words, awready/wready always 1 -> awaddr 0x0140_0040, awlen 63, 64 beats, wlast on beat 64, no frm_done.
REQ-033 Contention: req0 and req1 high together -> ack0 first, then ack1; repeated contention -> grants alternate.
REQ-034 Backpressure: wready toggling 1/0, awready delayed 20 cycles, 64-word burst -> all 64 words in order, no err.
REQ-035 Frame end: cmd 0x23F (last=1) -> frm_done[0] pulses once after bvalid.
REQ-036 Error: bresp 2'b10 -> err=1 and held; err_clr -> 0; err_clr on the same cycle as a new error -> err stays 1.
REQ-037 Reset: rst_n pulsed during DATA -> all outputs 0 and state IDLE; the next req1 burst completes correctly.
